// File: rtl/aes_sbox_arbiter_pkg.sv
// Shared AES S-box arbiter constants and the lookup payload carried down the response pipeline.
package aes_sbox_arbiter_pkg;

  localparam int unsigned SBOX_W = 32;

  localparam logic REQ_KEYMEM = 1'b0;
  localparam logic REQ_ENC    = 1'b1;

  typedef struct packed {
    logic              valid;
    logic              id;
    logic [SBOX_W-1:0] word;
  } sbox_stage_t;

endpackage

// File: rtl/aes_sbox_arb_pipe.sv
// Valid/id/data delay line of DEPTH stages between the shared S-box and the response demux.
module aes_sbox_arb_pipe
  import aes_sbox_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  sbox_stage_t in_stage,
  output sbox_stage_t out_stage,
  output logic        any_valid
);

  sbox_stage_t line_q [DEPTH];

  // Data only loads with a real lookup so the tail word stays meaningful between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q[0].valid <= in_stage.valid;
      line_q[0].id    <= in_stage.id;
      if (in_stage.valid) begin
        line_q[0].word <= in_stage.word;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      any_valid = any_valid | line_q[i].valid;
    end
  end

  assign out_stage = line_q[DEPTH-1];

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Shares one 32-bit forward S-box between key expansion (0) and encipher (1), in-order fixed-latency responses.
// Optional grant locking is enabled by defining AES_SBOX_ARB_LOCK_EN.
module aes_sbox_arbiter
  import aes_sbox_arbiter_pkg::*;
#(
  parameter int unsigned SBOX_LATENCY = 1,
  parameter int unsigned LOCK_MAX     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              req0_valid,
  input  logic [SBOX_W-1:0] req0_word,
  output logic              req0_ready,
  input  logic              lock0,
  output logic              rsp0_valid,
  output logic [SBOX_W-1:0] rsp0_word,
  input  logic              req1_valid,
  input  logic [SBOX_W-1:0] req1_word,
  output logic              req1_ready,
  input  logic              lock1,
  output logic              rsp1_valid,
  output logic [SBOX_W-1:0] rsp1_word,
  output logic [SBOX_W-1:0] sboxw,
  input  logic [SBOX_W-1:0] new_sboxw,
  output logic              busy
);

  logic              last_grant_q;
  logic              grant;
  logic              winner;
  logic              lock_sel;
  logic              pipe_busy;
  sbox_stage_t       issue;
  sbox_stage_t       tail;
  logic [SBOX_W-1:0] hold0_q;
  logic [SBOX_W-1:0] hold1_q;

`ifdef AES_SBOX_ARB_LOCK_EN
  localparam int unsigned CTR_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

  logic [CTR_W-1:0] lock_ctr_q;
  logic             prev_xfer_q;
  logic             locked_win;

  // Lock follows the previous winner; saturated counter forces one round-robin decision.
  always_comb begin
    lock_sel = 1'b0;
    if (lock_ctr_q != CTR_W'(LOCK_MAX)) begin
      lock_sel = (last_grant_q == REQ_ENC) ? (lock1 & req1_valid) : (lock0 & req0_valid);
    end
  end

  // A lock only counts once the requester already holds the grant from the previous cycle.
  assign locked_win = grant & lock_sel & prev_xfer_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_ctr_q  <= '0;
      prev_xfer_q <= 1'b0;
    end else begin
      prev_xfer_q <= grant;
      if (grant) begin
        lock_ctr_q <= locked_win ? lock_ctr_q + CTR_W'(1) : '0;
      end
    end
  end
`else
  logic unused_lock;

  assign lock_sel    = 1'b0;
  assign unused_lock = ^{lock0, lock1, 32'(LOCK_MAX)};
`endif

  // Grant is combinational; reset_n gates it so nothing is offered while held in reset.
  always_comb begin
    grant = enable & reset_n & (req0_valid | req1_valid);
    if (lock_sel) begin
      winner = last_grant_q;
    end else if (req0_valid & req1_valid) begin
      winner = ~last_grant_q;
    end else if (req1_valid) begin
      winner = REQ_ENC;
    end else begin
      winner = REQ_KEYMEM;
    end
  end

  assign req0_ready = grant & (winner == REQ_KEYMEM);
  assign req1_ready = grant & (winner == REQ_ENC);
  assign sboxw      = grant ? ((winner == REQ_ENC) ? req1_word : req0_word) : '0;

  always_comb begin
    issue       = '0;
    issue.valid = grant;
    issue.id    = winner;
    issue.word  = new_sboxw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= REQ_ENC;
    end else if (grant) begin
      last_grant_q <= winner;
    end
  end

  aes_sbox_arb_pipe #(
    .DEPTH (SBOX_LATENCY)
  ) u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_stage  (issue),
    .out_stage (tail),
    .any_valid (pipe_busy)
  );

  // Each requester sees its own last result between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (rsp0_valid) begin
        hold0_q <= tail.word;
      end
      if (rsp1_valid) begin
        hold1_q <= tail.word;
      end
    end
  end

  assign rsp0_valid = tail.valid & (tail.id == REQ_KEYMEM);
  assign rsp1_valid = tail.valid & (tail.id == REQ_ENC);
  assign rsp0_word  = rsp0_valid ? tail.word : hold0_q;
  assign rsp1_word  = rsp1_valid ? tail.word : hold1_q;

  assign busy = grant | pipe_busy;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter: one instance at latency 1 and one at latency 2 share the stimulus.
module tb_aes_sbox_arbiter;
  import aes_sbox_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, enable;
  logic        req0_valid, req1_valid, lock0, lock1;
  logic [31:0] req0_word, req1_word;

  logic        rdy0_1, rdy1_1, rv0_1, rv1_1, busy_1;
  logic [31:0] rw0_1, rw1_1, sb_1, nsb_1;
  logic        rdy0_2, rdy1_2, rv0_2, rv1_2, busy_2;
  logic [31:0] rw0_2, rw1_2, sb_2, nsb_2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox_b(input logic [7:0] b);
    case (b)
      8'h00:   return 8'h63;
      8'h01:   return 8'h7c;
      8'h02:   return 8'h77;
      8'h03:   return 8'h7b;
      8'h10:   return 8'hca;
      8'h11:   return 8'h82;
      8'h12:   return 8'hc9;
      8'h13:   return 8'h7d;
      8'h53:   return 8'hed;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sbox_w(input logic [31:0] w);
    return {sbox_b(w[31:24]), sbox_b(w[23:16]), sbox_b(w[15:8]), sbox_b(w[7:0])};
  endfunction

  assign nsb_1 = sbox_w(sb_1);
  assign nsb_2 = sbox_w(sb_2);

  aes_sbox_arbiter #(.SBOX_LATENCY(1), .LOCK_MAX(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req0_valid(req0_valid), .req0_word(req0_word), .req0_ready(rdy0_1), .lock0(lock0),
    .rsp0_valid(rv0_1), .rsp0_word(rw0_1),
    .req1_valid(req1_valid), .req1_word(req1_word), .req1_ready(rdy1_1), .lock1(lock1),
    .rsp1_valid(rv1_1), .rsp1_word(rw1_1),
    .sboxw(sb_1), .new_sboxw(nsb_1), .busy(busy_1)
  );

  aes_sbox_arbiter #(.SBOX_LATENCY(2), .LOCK_MAX(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req0_valid(req0_valid), .req0_word(req0_word), .req0_ready(rdy0_2), .lock0(lock0),
    .rsp0_valid(rv0_2), .rsp0_word(rw0_2),
    .req1_valid(req1_valid), .req1_word(req1_word), .req1_ready(rdy1_2), .lock1(lock1),
    .rsp1_valid(rv1_2), .rsp1_word(rw1_2),
    .sboxw(sb_2), .new_sboxw(nsb_2), .busy(busy_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic        g;
    logic [7:0]  b;
    logic [6:0]  exp_lock;
    int          n_rsp;

    reset_n = 1'b0; enable = 1'b1;
    req0_valid = 1'b1; req0_word = 32'h0;
    req1_valid = 1'b0; req1_word = 32'h0;
    lock0 = 1'b0; lock1 = 1'b0;

    // Reset held with a pending request
    mid(); mid();
    chk("rst_rdy0_1", 32'(rdy0_1), 32'd0);
    chk("rst_rdy1_1", 32'(rdy1_1), 32'd0);
    chk("rst_rdy0_2", 32'(rdy0_2), 32'd0);
    chk("rst_rv0_1", 32'(rv0_1), 32'd0);
    chk("rst_rv1_1", 32'(rv1_1), 32'd0);
    chk("rst_busy_1", 32'(busy_1), 32'd0);
    chk("rst_busy_2", 32'(busy_2), 32'd0);
    chk("rst_rw0_1", rw0_1, 32'h0);

    cyc(); reset_n = 1'b1;
    mid();
    chk("rel_rdy0_1", 32'(rdy0_1), 32'd1);
    chk("rel_rdy0_2", 32'(rdy0_2), 32'd1);
    chk("rel_busy_1", 32'(busy_1), 32'd1);

    // Single request response
    cyc(); req0_valid = 1'b0;
    mid();
    chk("single_rv0_1", 32'(rv0_1), 32'd1);
    chk("single_rw0_1", rw0_1, 32'h63636363);
    chk("single_rv1_1", 32'(rv1_1), 32'd0);
    chk("single_rv0_2_early", 32'(rv0_2), 32'd0);
    cyc();
    mid();
    chk("single_rv0_1_pulse", 32'(rv0_1), 32'd0);
    chk("single_rw0_1_hold", rw0_1, 32'h63636363);
    chk("single_rv0_2", 32'(rv0_2), 32'd1);
    chk("single_rw0_2", rw0_2, 32'h63636363);
    chk("single_rv1_2", 32'(rv1_2), 32'd0);
    cyc();
    mid();
    chk("idle_busy_1", 32'(busy_1), 32'd0);
    chk("idle_busy_2", 32'(busy_2), 32'd0);

    // Reset one cycle after a grant discards the lookup
    cyc(); req1_valid = 1'b1; req1_word = 32'h01010101;
    mid();
    chk("mf_rdy1_2", 32'(rdy1_2), 32'd1);
    cyc(); req1_valid = 1'b0; reset_n = 1'b0;
    mid();
    chk("mf_rv1_2_a", 32'(rv1_2), 32'd0);
    chk("mf_busy_2", 32'(busy_2), 32'd0);
    chk("mf_rv1_1", 32'(rv1_1), 32'd0);
    cyc();
    mid();
    chk("mf_rv1_2_b", 32'(rv1_2), 32'd0);
    cyc(); reset_n = 1'b1; req1_valid = 1'b1; req1_word = 32'h02020202;
    mid();
    chk("mf_rdy1_1", 32'(rdy1_1), 32'd1);
    cyc(); req1_valid = 1'b0;
    mid();
    chk("mf_rv1_1_after", 32'(rv1_1), 32'd1);
    chk("mf_rw1_1_after", rw1_1, 32'h77777777);
    cyc();
    mid();
    chk("mf_rv1_2_after", 32'(rv1_2), 32'd1);
    chk("mf_rw1_2_after", rw1_2, 32'h77777777);

    // Contention: last grant was requester 1, so order is 0,1,0,1
    cyc();
    req0_word = 32'h53535353; req1_word = 32'h01010101;
    for (int c = 0; c < 6; c++) begin
      req0_valid = (c < 4); req1_valid = (c < 4);
      mid();
      if (c < 4) begin
        g = 1'(c % 2);
        chk($sformatf("cont_rdy0_1[%0d]", c), 32'(rdy0_1), 32'(!g));
        chk($sformatf("cont_rdy1_1[%0d]", c), 32'(rdy1_1), 32'(g));
        chk($sformatf("cont_rdy1_2[%0d]", c), 32'(rdy1_2), 32'(g));
        chk($sformatf("cont_sboxw_1[%0d]", c), sb_1, g ? 32'h01010101 : 32'h53535353);
      end
      if (c >= 1 && c <= 4) begin
        g = 1'((c - 1) % 2);
        chk($sformatf("cont_rv0_1[%0d]", c), 32'(rv0_1), 32'(!g));
        chk($sformatf("cont_rv1_1[%0d]", c), 32'(rv1_1), 32'(g));
        chk($sformatf("cont_rw_1[%0d]", c), g ? rw1_1 : rw0_1, g ? 32'h7c7c7c7c : 32'hedededed);
      end
      if (c >= 2) begin
        g = 1'((c - 2) % 2);
        chk($sformatf("cont_rv0_2[%0d]", c), 32'(rv0_2), 32'(!g));
        chk($sformatf("cont_rv1_2[%0d]", c), 32'(rv1_2), 32'(g));
        chk($sformatf("cont_rw_2[%0d]", c), g ? rw1_2 : rw0_2, g ? 32'h7c7c7c7c : 32'hedededed);
      end
      cyc();
    end

    // Back-to-back stream from requester 1
    for (int c = 0; c < 6; c++) begin
      req1_valid = (c < 4);
      b = 8'(c);
      req1_word = {4{b}};
      mid();
      if (c < 4) chk($sformatf("strm_rdy1_2[%0d]", c), 32'(rdy1_2), 32'd1);
      if (c >= 2) begin
        b = 8'(c - 2);
        chk($sformatf("strm_rv1_2[%0d]", c), 32'(rv1_2), 32'd1);
        chk($sformatf("strm_rw1_2[%0d]", c), rw1_2, {4{sbox_b(b)}});
      end else begin
        chk($sformatf("strm_rv1_2[%0d]", c), 32'(rv1_2), 32'd0);
      end
      if (c >= 1 && c <= 4) begin
        b = 8'(c - 1);
        chk($sformatf("strm_rw1_1[%0d]", c), rw1_1, {4{sbox_b(b)}});
      end
      chk($sformatf("strm_rv0_2[%0d]", c), 32'(rv0_2), 32'd0);
      cyc();
    end

    // Enable dropped after the second grant: exactly two responses
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      req1_valid = (c < 4);
      enable = (c < 2);
      b = 8'(8'h10 + c);
      req1_word = {4{b}};
      mid();
      chk($sformatf("en_rdy1_2[%0d]", c), 32'(rdy1_2), 32'(c < 2));
      chk($sformatf("en_rv1_2[%0d]", c), 32'(rv1_2), 32'(c == 2 || c == 3));
      if (rv1_2) n_rsp++;
      if (c == 2) chk("en_rw1_2_first", rw1_2, 32'hcacacaca);
      if (c == 3) chk("en_rw1_2_second", rw1_2, 32'h82828282);
      if (c == 3) chk("en_busy_2_draining", 32'(busy_2), 32'd1);
      if (c == 4) chk("en_busy_2_done", 32'(busy_2), 32'd0);
      cyc();
    end
    chk("en_rsp_count", 32'(n_rsp), 32'd2);

    // Lock behaviour from a fresh reset
    enable = 1'b1;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
`ifdef AES_SBOX_ARB_LOCK_EN
    exp_lock = 7'b1011111;
`else
    exp_lock = 7'b0101010;
`endif
    lock1 = 1'b1;
    req0_word = 32'h53535353; req1_word = 32'h01010101;
    for (int c = 0; c < 7; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      mid();
      g = exp_lock[c];
      chk($sformatf("lock_rdy1_1[%0d]", c), 32'(rdy1_1), 32'(g));
      chk($sformatf("lock_rdy0_2[%0d]", c), 32'(rdy0_2), 32'(!g));
      chk($sformatf("lock_sboxw_1[%0d]", c), sb_1, g ? 32'h01010101 : 32'h53535353);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; lock1 = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
